// File: rtl/ehl_ahb_matrix_in_buf_if.sv
// rtl/ehl_ahb_matrix_in_buf_if.sv - master-side and output-stage bus bundle of one matrix input port
interface ehl_ahb_matrix_in_buf_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SNUM = 4
);
    logic                 remap;
    logic [SNUM-1:0]      route;
    logic [AW-1:0]        haddr;
    logic [1:0]           htrans;
    logic                 hwrite;
    logic [2:0]           hsize;
    logic [2:0]           hburst;
    logic [3:0]           hprot;
    logic                 om_hready;
    logic [1:0]           om_hresp;
    logic [DW-1:0]        om_hrdata;
    logic [AW-1:0]        os_haddr;
    logic                 os_hwrite;
    logic [2:0]           os_hsize;
    logic [2:0]           os_hburst;
    logic [3:0]           os_hprot;
    logic [2*SNUM-1:0]    os_htrans;
    logic [SNUM-1:0]      is_hgrant;
    logic [SNUM-1:0]      is_hready;
    logic [2*SNUM-1:0]    is_hresp;
    logic [DW*SNUM-1:0]   is_hrdata;

    // Input-stage view: receives the master bus and slave responses.
    modport slave (
        input  remap, route, haddr, htrans, hwrite, hsize, hburst, hprot,
        input  is_hgrant, is_hready, is_hresp, is_hrdata,
        output om_hready, om_hresp, om_hrdata,
        output os_haddr, os_hwrite, os_hsize, os_hburst, os_hprot, os_htrans
    );

    // Environment view: master plus output stages.
    modport master (
        output remap, route, haddr, htrans, hwrite, hsize, hburst, hprot,
        output is_hgrant, is_hready, is_hresp, is_hrdata,
        input  om_hready, om_hresp, om_hrdata,
        input  os_haddr, os_hwrite, os_hsize, os_hburst, os_hprot, os_htrans
    );
endinterface

// File: rtl/ehl_ahb_matrix_in_buf.sv
// rtl/ehl_ahb_matrix_in_buf.sv - AHB matrix input stage: decode, hold buffer, response mux, default slave
module ehl_ahb_matrix_in_buf #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SNUM = 4,
    parameter logic [SNUM*AW-1:0] SLV_BASE  = '0,
    parameter logic [SNUM*AW-1:0] SLV_MASK  = '0,
    parameter logic [SNUM*AW-1:0] RSLV_BASE = '0,
    parameter logic [SNUM*AW-1:0] RSLV_MASK = '0
) (
    input logic                   hclk,
    input logic                   hreset,
    ehl_ahb_matrix_in_buf_if.slave bus
);
    localparam int SW = (SNUM > 1) ? $clog2(SNUM) : 1;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        r_state;
    logic [SW-1:0] r_sel_d;
    logic [SW-1:0] r_hold_sel;
    logic [AW-1:0] r_hold_addr;
    logic          r_hold_write;
    logic [2:0]    r_hold_size;
    logic [2:0]    r_hold_burst;
    logic [3:0]    r_hold_prot;

    logic [SW-1:0] w_sel;
    logic          w_mapped;
    logic          w_slot;
    logic          w_accept;

    // Address decode: lowest-index permitted slave whose masked address matches its base.
    always_comb begin
        w_sel    = '0;
        w_mapped = 1'b0;
        for (int i = SNUM - 1; i >= 0; i--) begin
            if (bus.route[i] &&
                ((bus.haddr & (bus.remap ? RSLV_MASK[i*AW +: AW] : SLV_MASK[i*AW +: AW])) ==
                 (bus.remap ? RSLV_BASE[i*AW +: AW] : SLV_BASE[i*AW +: AW]))) begin
                w_sel    = SW'(i);
                w_mapped = 1'b1;
            end
        end
    end

    // A new address phase can be taken whenever the master sees HREADY high.
    assign w_slot   = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                      ((r_state == S_DATA) && bus.is_hready[r_sel_d]);
    assign w_accept = w_slot && bus.htrans[1] && !hreset;

    // Master-facing response: slave data phase, default-slave error, or zero-wait OKAY.
    always_comb begin
        bus.om_hready = 1'b1;
        bus.om_hresp  = 2'b00;
        bus.om_hrdata = '0;
        case (r_state)
            S_HOLD: bus.om_hready = 1'b0;
            S_DATA: begin
                bus.om_hready = bus.is_hready[r_sel_d];
                bus.om_hresp  = bus.is_hresp[r_sel_d*2 +: 2];
                bus.om_hrdata = bus.is_hrdata[r_sel_d*DW +: DW];
            end
            S_ERR1: begin
                bus.om_hready = 1'b0;
                bus.om_hresp  = 2'b01;
            end
            S_ERR2: bus.om_hresp = 2'b01;
            default: ;
        endcase
    end

    // Output-stage address phase: held copy while waiting for grant, else the live master bus.
    always_comb begin
        bus.os_haddr  = '0;
        bus.os_hwrite = 1'b0;
        bus.os_hsize  = '0;
        bus.os_hburst = '0;
        bus.os_hprot  = '0;
        bus.os_htrans = '0;
        if (!hreset) begin
            if (r_state == S_HOLD) begin
                bus.os_haddr  = r_hold_addr;
                bus.os_hwrite = r_hold_write;
                bus.os_hsize  = r_hold_size;
                bus.os_hburst = r_hold_burst;
                bus.os_hprot  = r_hold_prot;
                bus.os_htrans[r_hold_sel*2 +: 2] = HT_NONSEQ;
            end else begin
                bus.os_haddr  = bus.haddr;
                bus.os_hwrite = bus.hwrite;
                bus.os_hsize  = bus.hsize;
                bus.os_hburst = bus.hburst;
                bus.os_hprot  = bus.hprot;
                if (w_accept && w_mapped) begin
                    bus.os_htrans[w_sel*2 +: 2] = bus.htrans;
                end
            end
        end
    end

    // Transfer sequencing: grant/hold, data phase tracking and the two-cycle default-slave error.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state      <= S_IDLE;
            r_sel_d      <= '0;
            r_hold_sel   <= '0;
            r_hold_addr  <= '0;
            r_hold_write <= 1'b0;
            r_hold_size  <= '0;
            r_hold_burst <= '0;
            r_hold_prot  <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (bus.is_hgrant[r_hold_sel]) begin
                        r_state <= S_DATA;
                        r_sel_d <= r_hold_sel;
                    end
                end
                S_ERR1: r_state <= S_ERR2;
                default: begin
                    if (w_slot) begin
                        if (!w_accept) begin
                            r_state <= S_IDLE;
                        end else if (!w_mapped) begin
                            r_state <= S_ERR1;
                        end else if (bus.is_hgrant[w_sel]) begin
                            r_state <= S_DATA;
                            r_sel_d <= w_sel;
                        end else begin
                            r_state      <= S_HOLD;
                            r_hold_sel   <= w_sel;
                            r_hold_addr  <= bus.haddr;
                            r_hold_write <= bus.hwrite;
                            r_hold_size  <= bus.hsize;
                            r_hold_burst <= bus.hburst;
                            r_hold_prot  <= bus.hprot;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ehl_ahb_matrix_in_buf.sv
// tb/tb_ehl_ahb_matrix_in_buf.sv - directed bench with transaction-level reference model
module tb_ehl_ahb_matrix_in_buf;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 hclk = ~hclk;

    ehl_ahb_matrix_in_buf_if #(.AW(32), .DW(32), .SNUM(4)) ifc ();

    ehl_ahb_matrix_in_buf #(
        .AW(32), .DW(32), .SNUM(4),
        .SLV_BASE ({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .SLV_MASK ({4{32'hF000_0000}}),
        .RSLV_BASE({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000}),
        .RSLV_MASK({4{32'hF000_0000}})
    ) dut (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (ifc)
    );

    // Slave map as the bench sees it.
    logic [31:0] nbase [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    logic [31:0] rbase [4] = '{32'h0000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};

    function automatic int decode(input logic [31:0] a, input logic rm, input logic [3:0] rt);
        for (int i = 0; i < 4; i++) begin
            if (rt[i] && ((a & 32'hF000_0000) == (rm ? rbase[i] : nbase[i]))) return i;
        end
        return -1;
    endfunction

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one pending (ungranted) address phase, one data phase owner, or an error countdown.
    bit          p_valid = 0;
    int          p_sel   = 0;
    logic [31:0] p_addr;
    logic        p_write;
    logic [2:0]  p_size, p_burst;
    logic [3:0]  p_prot;
    int          d_slave = -1;
    int          e_left  = 0;

    logic        m_hready;
    logic [1:0]  m_hresp;
    logic [31:0] m_hrdata;
    int          m_sel;
    logic [7:0]  m_htrans;
    logic [31:0] m_haddr;
    logic        m_hwrite;
    logic [2:0]  m_hsize, m_hburst;
    logic [3:0]  m_hprot;

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = 2'b00;
        m_hrdata = 32'h0;
        m_htrans = 8'h0;
        m_sel    = decode(ifc.haddr, ifc.remap, ifc.route);
        if (p_valid) m_hready = 1'b0;
        else if (e_left > 0) begin
            m_hready = (e_left == 1);
            m_hresp  = 2'b01;
        end else if (d_slave >= 0) begin
            m_hready = ifc.is_hready[d_slave];
            m_hresp  = ifc.is_hresp[d_slave*2 +: 2];
            m_hrdata = ifc.is_hrdata[d_slave*32 +: 32];
        end
        m_haddr  = p_valid ? p_addr  : ifc.haddr;
        m_hwrite = p_valid ? p_write : ifc.hwrite;
        m_hsize  = p_valid ? p_size  : ifc.hsize;
        m_hburst = p_valid ? p_burst : ifc.hburst;
        m_hprot  = p_valid ? p_prot  : ifc.hprot;
        if (p_valid) m_htrans[p_sel*2 +: 2] = NONSEQ;
        else if (m_hready && ifc.htrans[1] && m_sel >= 0) m_htrans[m_sel*2 +: 2] = ifc.htrans;
        if (hreset) begin
            m_htrans = 8'h0;
            m_haddr  = 32'h0;
            m_hwrite = 1'b0;
            m_hsize  = 3'h0;
            m_hburst = 3'h0;
            m_hprot  = 4'h0;
        end
    end

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            p_valid <= 0;
            d_slave <= -1;
            e_left  <= 0;
        end else if (p_valid) begin
            if (ifc.is_hgrant[p_sel]) begin
                p_valid <= 0;
                d_slave <= p_sel;
            end
        end else if (!m_hready) begin
            if (e_left == 2) e_left <= 1;
        end else begin
            d_slave <= -1;
            e_left  <= 0;
            if (ifc.htrans[1]) begin
                if (m_sel < 0) e_left <= 2;
                else if (ifc.is_hgrant[m_sel]) d_slave <= m_sel;
                else begin
                    p_valid <= 1;
                    p_sel   <= m_sel;
                    p_addr  <= ifc.haddr;
                    p_write <= ifc.hwrite;
                    p_size  <= ifc.hsize;
                    p_burst <= ifc.hburst;
                    p_prot  <= ifc.hprot;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge hclk) begin
        lit("om_hready", ifc.om_hready, m_hready);
        lit("om_hresp",  ifc.om_hresp,  m_hresp);
        lit("om_hrdata", ifc.om_hrdata, m_hrdata);
        lit("os_htrans", ifc.os_htrans, m_htrans);
        if (m_htrans != 8'h0 || hreset) begin
            lit("os_haddr",  ifc.os_haddr,  m_haddr);
            lit("os_hwrite", ifc.os_hwrite, m_hwrite);
            lit("os_hsize",  ifc.os_hsize,  m_hsize);
            lit("os_hburst", ifc.os_hburst, m_hburst);
            lit("os_hprot",  ifc.os_hprot,  m_hprot);
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    int cnt;

    initial begin
        hreset         = 1'b1;
        ifc.remap      = 1'b0;
        ifc.route      = 4'hF;
        ifc.haddr      = 32'h2000_0010;
        ifc.htrans     = NONSEQ;
        ifc.hwrite     = 1'b0;
        ifc.hsize      = 3'b010;
        ifc.hburst     = 3'b000;
        ifc.hprot      = 4'h3;
        ifc.is_hgrant  = 4'hF;
        ifc.is_hready  = 4'hF;
        ifc.is_hresp   = 8'h0;
        ifc.is_hrdata  = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};

        // Reset state
        mid();
        lit("rst_hready", ifc.om_hready, 1'b1);
        lit("rst_hresp",  ifc.om_hresp,  2'b00);
        lit("rst_hrdata", ifc.om_hrdata, 32'h0);
        lit("rst_htrans", ifc.os_htrans, 8'h00);
        lit("rst_haddr",  ifc.os_haddr,  32'h0);
        tick();
        hreset = 1'b0;
        ifc.htrans = IDLE;
        tick();

        // Granted read with two slave wait states
        ifc.haddr = 32'h2000_0010; ifc.htrans = NONSEQ;
        mid();
        lit("t1_c0_htrans", ifc.os_htrans, 8'h08);
        lit("t1_c0_hready", ifc.om_hready, 1'b1);
        tick();
        ifc.htrans = IDLE; ifc.is_hready[1] = 1'b0;
        mid(); lit("t1_c1_hready", ifc.om_hready, 1'b0);
        tick();
        mid(); lit("t1_c2_hready", ifc.om_hready, 1'b0);
        tick();
        ifc.is_hready[1] = 1'b1; ifc.is_hrdata[63:32] = 32'hDEAD_BEEF;
        mid();
        lit("t1_c3_hready", ifc.om_hready, 1'b1);
        lit("t1_c3_hrdata", ifc.om_hrdata, 32'hDEAD_BEEF);
        lit("t1_c3_hresp",  ifc.om_hresp,  2'b00);
        tick();

        // Grant withheld three cycles: held NONSEQ while master address moves
        ifc.haddr = 32'h2000_0010; ifc.htrans = SEQ; ifc.hwrite = 1'b1; ifc.is_hgrant = 4'b1101;
        mid(); lit("t2_c0_htrans", ifc.os_htrans, 8'h0C);
        tick();
        ifc.haddr = 32'h5555_0000; ifc.htrans = NONSEQ; ifc.hwrite = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) ifc.is_hgrant = 4'hF;
            mid();
            lit("t2_hold_haddr",  ifc.os_haddr,  32'h2000_0010);
            lit("t2_hold_htrans", ifc.os_htrans, 8'h08);
            lit("t2_hold_hready", ifc.om_hready, 1'b0);
            tick();
        end
        ifc.htrans = IDLE; ifc.is_hrdata[63:32] = 32'h1234_5678;
        mid();
        lit("t2_data_hready", ifc.om_hready, 1'b1);
        lit("t2_data_hrdata", ifc.om_hrdata, 32'h1234_5678);
        tick();

        // Unmapped access, then route-blocked access
        for (int k = 0; k < 2; k++) begin
            ifc.haddr  = (k == 0) ? 32'h9000_0000 : 32'h2000_0000;
            ifc.route  = (k == 0) ? 4'hF : 4'b1101;
            ifc.htrans = NONSEQ;
            mid(); lit("t3_c0_htrans", ifc.os_htrans, 8'h00);
            tick();
            ifc.htrans = IDLE;
            mid();
            lit("t3_err1_hready", ifc.om_hready, 1'b0);
            lit("t3_err1_hresp",  ifc.om_hresp,  2'b01);
            tick();
            mid();
            lit("t3_err2_hready", ifc.om_hready, 1'b1);
            lit("t3_err2_hresp",  ifc.om_hresp,  2'b01);
            tick();
        end
        ifc.route = 4'hF;

        // Remap: 0x4 hits slave0 only in the remapped map
        ifc.remap = 1'b1; ifc.haddr = 32'h0000_0004; ifc.htrans = NONSEQ;
        mid(); lit("t4_remap_htrans", ifc.os_htrans, 8'h02);
        tick();
        ifc.htrans = IDLE;
        mid(); lit("t4_remap_hrdata", ifc.om_hrdata, 32'hC0C0_0000);
        tick();
        ifc.remap = 1'b0; ifc.htrans = NONSEQ;
        mid(); lit("t4_norm_htrans", ifc.os_htrans, 8'h00);
        tick();
        ifc.htrans = IDLE;
        mid(); lit("t4_norm_hresp", ifc.om_hresp, 2'b01);
        tick();
        tick();

        // Back-to-back burst of four to slave2
        cnt = 0;
        for (int b = 0; b < 4; b++) begin
            ifc.haddr  = 32'h3000_0000 + 32'(b * 4);
            ifc.htrans = (b == 0) ? NONSEQ : SEQ;
            mid();
            if (ifc.om_hready && ifc.os_htrans[5:4] != 2'b00) cnt++;
            tick();
        end
        lit("t5_burst_count", cnt, 4);
        ifc.htrans = IDLE;
        mid(); lit("t5_last_hrdata", ifc.om_hrdata, 32'hC2C2_0002);
        tick();

        // Reset while holding
        ifc.haddr = 32'h2000_0010; ifc.htrans = NONSEQ; ifc.is_hgrant = 4'b0000;
        tick();
        mid(); lit("t6_hold_hready", ifc.om_hready, 1'b0);
        #1 hreset = 1'b1;
        #1 lit("t6_rst_htrans", ifc.os_htrans, 8'h00);
        tick();
        hreset = 1'b0; ifc.htrans = IDLE; ifc.is_hgrant = 4'hF;
        mid();
        lit("t6_after_hready", ifc.om_hready, 1'b1);
        lit("t6_after_htrans", ifc.os_htrans, 8'h00);
        tick();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ehl_ahb_matrix_in_buf.md
Name: ehl_ahb_matrix_in_buf

Overview:
- Parametrised AHB matrix input stage, one instance per master port.
- Decodes the master address phase against a packed, remappable slave map and forwards it to the per-slave output stages.
- Buffers the address phase in a hold register when the selected output stage does not grant it in the same cycle.
- Returns the selected slave's data-phase response, or a built-in default-slave two-cycle ERROR for unmapped or route-blocked accesses.

Parameters:
- AW, 32: address width (12..64).
- DW, 32: data width (32, 64, 128).
- SNUM, 4: number of slave ports (1..16).
- SLV_BASE, {SNUM*AW{1'b0}}: packed base addresses; slice i at [i*AW+:AW].
- SLV_MASK, {SNUM*AW{1'b0}}: packed decode masks, normal map.
- RSLV_BASE, {SNUM*AW{1'b0}}: packed base addresses, remapped map.
- RSLV_MASK, {SNUM*AW{1'b0}}: packed decode masks, remapped map.

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous active-high reset
- remap  in  1  selects RSLV_* map when 1
- route  in  SNUM  per-slave access permission for this master
- haddr  in  AW  master address
- htrans  in  2  master transfer type
- hwrite  in  1  master write
- hsize  in  3  master size
- hburst  in  3  master burst
- hprot  in  4  master protection
- om_hready  out  1  HREADY to master
- om_hresp  out  2  HRESP to master
- om_hrdata  out  DW  read data to master
- os_haddr  out  AW  address to all output stages
- os_hwrite  out  1  to all output stages
- os_hsize  out  3  to all output stages
- os_hburst  out  3  to all output stages
- os_hprot  out  4  to all output stages
- os_htrans  out  2*SNUM  per-slave transfer type; zero for non-selected slaves
- is_hgrant  in  SNUM  output stage i accepts the presented address phase this cycle
- is_hready  in  SNUM  per-slave data-phase HREADY
- is_hresp  in  2*SNUM  per-slave HRESP
- is_hrdata  in  DW*SNUM  per-slave read data

Behaviour:
- Decode: hit[i] = ((a & MASK_i) == BASE_i), with BASE/MASK taken from RSLV_* when remap=1 else SLV_*.
  - sel = lowest-index i with hit[i] & route[i].
  - No such i: the access is unmapped.
- Accept: the master transfer is accepted when om_hready=1 and htrans is NONSEQ or SEQ.
  - IDLE and BUSY are never forwarded; they complete zero-wait OKAY.
- State machine states: IDLE, HOLD, DATA, ERR1, ERR2. Reset → IDLE.
- Outputs per state:
  - IDLE: om_hready=1.
  - HOLD: om_hready=0.
  - DATA: om_hready=is_hready[sel_d], om_hresp/om_hrdata from slave sel_d.
  - ERR1: om_hready=0, om_hresp=2'b01.
  - ERR2: om_hready=1, om_hresp=2'b01.
  - All other cases: om_hresp=0, om_hrdata=0.
- Next state on an accepted, mapped transfer:
  - Master controls drive os_* combinationally; os_htrans[sel] = htrans.
  - If is_hgrant[sel]=1 the same cycle: → DATA, sel_d <= sel.
  - Otherwise: controls captured into the hold register, → HOLD.
- Next state on an accepted, unmapped transfer: → ERR1, then ERR2, then IDLE. No os_htrans asserted.
- HOLD:
  - os_* driven from the hold register; os_htrans[held sel] = NONSEQ regardless of the original htrans.
  - Waits indefinitely for is_hgrant[held sel]; on grant → DATA.
  - remap/route changes do not re-decode a held transfer.
- DATA with is_hready[sel_d]=1: behaves as IDLE for acceptance (pipelined back-to-back). With no new transfer → IDLE.
- Slave ERROR responses pass through unmodified. A master that cancels to IDLE during ERR2 is accepted normally.
- ERR2 and completing DATA are accept cycles.
- Latency:
  - Granted transfer: zero added address-phase cycles.
  - Each non-grant cycle adds one wait state to the data phase.
- Reset (asynchronous, at any time, including mid-HOLD or mid-ERR1):
  - State → IDLE, hold register cleared, sel_d = 0.
  - Outputs: om_hready=1, om_hresp=0, om_hrdata=0, os_htrans all 0, os_haddr=0.
  - No transfer is replayed after reset.

Test Plan:
- SNUM=4, slave1 base 0x2000_0000 mask 0xF000_0000, route=4'hF: NONSEQ read 0x2000_0010 with is_hgrant[1]=1, is_hready[1] low 2 cycles, is_hrdata=0xDEADBEEF → os_htrans[3:2]=2'b10 in cycle 0, om_hready low 2 cycles, then om_hrdata=0xDEADBEEF with OKAY.
- Same access with is_hgrant[1] low 3 cycles → os_haddr held at 0x2000_0010 with NONSEQ for 3 cycles while master haddr changes; om_hready=0 throughout HOLD; data phase completes after grant.
- Access to 0x9000_0000 (unmapped), and to 0x2000_0000 with route[1]=0 → om_hready 0 then 1 with om_hresp=2'b01 both cycles; os_htrans stays 0.
- remap=1 with RSLV0 base 0x0000_0000 and SLV0 base 0x1000_0000 → 0x0000_0004 selects slave0 only when remap=1, default-slave ERROR when remap=0.
- Back-to-back SEQ burst of 4 with grant and zero-wait slaves → 4 transfers in 4 cycles, no HOLD.
- hreset asserted while in HOLD → next cycle om_hready=1, os_htrans=0, and no transfer issued after deassertion.
